sonar_frame_rx: RTL and testbench

- Receives the 7O1 serial stream produced by the sonar datapath and reassembles the 8-character measurement frame "AAA,DDD#".
- Exposes the frame as BCD angle and distance registers, with a one-cycle valid pulse per good frame.
- Sits downstream of the sonar transmitter, on the receiving/monitor side of the link.
- Performs UART reception, character validation and resynchronisation after errors.

---
 rtl/sonar_pkg.sv | 35 +++
 rtl/rx_serial_7O1.sv | 123 ++++++++++++
 rtl/sonar_frame_rx.sv | 112 +++++++++++
 tb/tb_sonar_frame_rx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared encodings and ASCII constants for the sonar frame receiver.
// Both receiver and parser state codes are visible on debug ports.
package sonar_pkg;

   typedef enum logic [2:0] {
      RX_IDLE   = 3'd0,
      RX_START  = 3'd1,
      RX_DATA   = 3'd2,
      RX_PARITY = 3'd3,
      RX_STOP   = 3'd4
   } rx_state_t;

   typedef enum logic [3:0] {
      P_SYNC = 4'd0,
      P_A2   = 4'd1,
      P_A1   = 4'd2,
      P_A0   = 4'd3,
      P_SEP  = 4'd4,
      P_D2   = 4'd5,
      P_D1   = 4'd6,
      P_D0   = 4'd7,
      P_END  = 4'd8
   } parse_state_t;

   localparam logic [6:0]  ASCII_DIGIT_BASE = 7'h30;
   localparam logic [6:0]  SEP_CHAR_DEF     = 7'h2C;
   localparam logic [6:0]  END_CHAR_DEF     = 7'h23;
   localparam int unsigned FRAME_LEN        = 8;
   localparam int unsigned DATA_BITS        = 7;

   function automatic logic is_digit(input logic [6:0] c);
      return (c >= ASCII_DIGIT_BASE) && (c <= ASCII_DIGIT_BASE + 7'd9);
   endfunction

endpackage

// File: rtl/rx_serial_7O1.sv
// 7O1 UART receiver: 2-flop synchroniser, mid-bit sampling, odd parity check.
// dado_valido and the error flags are one-cycle pulses issued after the stop sample.
module rx_serial_7O1
   import sonar_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [6:0] dado,
   output logic       dado_valido,
   output logic       erro_paridade,
   output logic       erro_parada,
   output logic [2:0] db_estado
);

   localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
   localparam int unsigned HALF = CLKS_PER_BIT / 2;

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [6:0]    shreg_q, shreg_d;
   logic          par_q, par_d;
   logic          hold_q, hold_d;
   logic          valid_q, valid_d;
   logic          perr_q, perr_d;
   logic          ferr_q, ferr_d;
   logic          rx_meta_q, rx_sync_q;
   logic          tick_half, tick_full;

   assign tick_half = (cnt_q == CW'(HALF - 1));
   assign tick_full = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= RX_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shreg_q   <= '0;
         par_q     <= 1'b0;
         hold_q    <= 1'b0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shreg_q   <= shreg_d;
         par_q     <= par_d;
         hold_q    <= hold_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      par_d   = par_q;
      hold_d  = hold_q;
      valid_d = 1'b0;
      perr_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            // after a framing error the line must be seen high before a new start
            if (rx_sync_q)   hold_d  = 1'b0;
            else if (!hold_q) state_d = RX_START;
         end
         RX_START: begin
            if (tick_half) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (tick_full) begin
               cnt_d   = '0;
               shreg_d = {rx_sync_q, shreg_q[6:1]};
               if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_PARITY;
               else                            bit_d   = bit_q + 3'd1;
            end
         end
         RX_PARITY: begin
            if (tick_full) begin
               cnt_d   = '0;
               par_d   = rx_sync_q;
               state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (tick_full) begin
               cnt_d   = '0;
               valid_d = 1'b1;
               perr_d  = ~(^{shreg_q, par_q});
               ferr_d  = ~rx_sync_q;
               hold_d  = ~rx_sync_q;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   assign dado          = shreg_q;
   assign dado_valido   = valid_q;
   assign erro_paridade = perr_q;
   assign erro_parada   = ferr_q;
   assign db_estado     = state_q;

endmodule

// File: rtl/sonar_frame_rx.sv
// Reassembles "AAA,DDD#" frames from the 7O1 stream into BCD angle/distance.
// pronto/erro are decoded from the registered character strobe, so they sit one cycle after the stop sample.
module sonar_frame_rx
   import sonar_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [6:0]  SEP_CHAR     = SEP_CHAR_DEF,
   parameter logic [6:0]  END_CHAR     = END_CHAR_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   output logic [11:0] angulo,
   output logic [11:0] distancia,
   output logic        pronto,
   output logic        erro,
   output logic [3:0]  db_estado,
   output logic [2:0]  db_rx_estado
);

   logic [6:0]   dado;
   logic         dado_valido, erro_paridade, erro_parada, char_err;
   parse_state_t state_q, state_d;
   logic [11:0]  sh_a_q, sh_a_d, sh_d_q, sh_d_d;
   logic [11:0]  ang_q, ang_d, dist_q, dist_d;
   logic         pronto_c, erro_c, fmt_bad, digit;

   rx_serial_7O1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock         (clock),
      .reset         (reset),
      .rx            (rx),
      .dado          (dado),
      .dado_valido   (dado_valido),
      .erro_paridade (erro_paridade),
      .erro_parada   (erro_parada),
      .db_estado     (db_rx_estado)
   );

   assign char_err = erro_paridade | erro_parada;
   assign digit    = is_digit(dado);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= P_SYNC;
         sh_a_q  <= '0;
         sh_d_q  <= '0;
         ang_q   <= '0;
         dist_q  <= '0;
      end else begin
         state_q <= state_d;
         sh_a_q  <= sh_a_d;
         sh_d_q  <= sh_d_d;
         ang_q   <= ang_d;
         dist_q  <= dist_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sh_a_d   = sh_a_q;
      sh_d_d   = sh_d_q;
      ang_d    = ang_q;
      dist_d   = dist_q;
      pronto_c = 1'b0;
      erro_c   = 1'b0;
      fmt_bad  = 1'b0;
      if (dado_valido) begin
         if (char_err) begin
            erro_c  = 1'b1;
            sh_a_d  = '0;
            sh_d_d  = '0;
            state_d = P_SYNC;
         end else begin
            case (state_q)
               P_SYNC: if (dado == END_CHAR) state_d = P_A2;
               P_A2:   if (digit) begin sh_a_d[11:8] = dado[3:0]; state_d = P_A1;  end else fmt_bad = 1'b1;
               P_A1:   if (digit) begin sh_a_d[7:4]  = dado[3:0]; state_d = P_A0;  end else fmt_bad = 1'b1;
               P_A0:   if (digit) begin sh_a_d[3:0]  = dado[3:0]; state_d = P_SEP; end else fmt_bad = 1'b1;
               P_SEP:  if (dado == SEP_CHAR) state_d = P_D2; else fmt_bad = 1'b1;
               P_D2:   if (digit) begin sh_d_d[11:8] = dado[3:0]; state_d = P_D1;  end else fmt_bad = 1'b1;
               P_D1:   if (digit) begin sh_d_d[7:4]  = dado[3:0]; state_d = P_D0;  end else fmt_bad = 1'b1;
               P_D0:   if (digit) begin sh_d_d[3:0]  = dado[3:0]; state_d = P_END; end else fmt_bad = 1'b1;
               P_END: begin
                  if (dado == END_CHAR) begin
                     ang_d    = sh_a_q;
                     dist_d   = sh_d_q;
                     pronto_c = 1'b1;
                     state_d  = P_A2;
                  end else begin
                     fmt_bad = 1'b1;
                  end
               end
               default: state_d = P_SYNC;
            endcase
            // a misplaced terminator still marks a frame boundary, so realign directly
            if (fmt_bad) begin
               erro_c  = 1'b1;
               sh_a_d  = '0;
               sh_d_d  = '0;
               state_d = (dado == END_CHAR) ? P_A2 : P_SYNC;
            end
         end
      end
   end

   assign angulo    = ang_q;
   assign distancia = dist_q;
   assign pronto    = pronto_c;
   assign erro      = erro_c;
   assign db_estado = state_q;

endmodule

// File: tb/tb_sonar_frame_rx.sv
// Directed and randomized checks of sonar_frame_rx against a frame-pattern reference model.
module tb_sonar_frame_rx;

   localparam int unsigned CPB = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        rx    = 1'b1;
   logic [11:0] angulo, distancia;
   logic        pronto, erro;
   logic [3:0]  db_estado;
   logic [2:0]  db_rx_estado;

   int n_assert   = 0;
   int n_fail     = 0;
   int pronto_cnt = 0;
   int erro_cnt   = 0;
   int both_cnt   = 0;

   // reference model state
   int          m_pronto = 0;
   int          m_erro   = 0;
   bit          m_sync   = 0;
   logic [6:0]  m_buf[$];
   logic [11:0] m_ang  = '0;
   logic [11:0] m_dist = '0;

   always #5 clock = ~clock;

   sonar_frame_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clock        (clock),
      .reset        (reset),
      .rx           (rx),
      .angulo       (angulo),
      .distancia    (distancia),
      .pronto       (pronto),
      .erro         (erro),
      .db_estado    (db_estado),
      .db_rx_estado (db_rx_estado)
   );

   always @(negedge clock) begin
      if (pronto === 1'b1) pronto_cnt++;
      if (erro === 1'b1) erro_cnt++;
      if (pronto === 1'b1 && erro === 1'b1) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame pattern "DDD,DDD#": position 3 is the separator, 7 the terminator.
   function automatic bit fits(input int pos, input logic [6:0] c);
      if (pos == 3) return c == 7'h2C;
      if (pos == 7) return c == 7'h23;
      return (c >= 7'h30) && (c <= 7'h39);
   endfunction

   function automatic logic [3:0] dig(input int k);
      logic [6:0] v;
      v = m_buf[k] - 7'h30;
      return v[3:0];
   endfunction

   function automatic void model_char(input logic [6:0] c, input bit err);
      if (err) begin
         m_erro++;
         m_sync = 0;
         m_buf.delete();
      end else if (!m_sync) begin
         if (c == 7'h23) m_sync = 1;
      end else if (fits(m_buf.size(), c)) begin
         m_buf.push_back(c);
         if (m_buf.size() == 8) begin
            m_pronto++;
            m_ang  = {dig(0), dig(1), dig(2)};
            m_dist = {dig(4), dig(5), dig(6)};
            m_buf.delete();
         end
      end else begin
         m_erro++;
         m_buf.delete();
         m_sync = (c == 7'h23);
      end
   endfunction

   function automatic void model_reset();
      m_sync = 0;
      m_buf.delete();
      m_ang  = '0;
      m_dist = '0;
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      rx = b;
      idle(CPB);
   endtask

   task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop);
      logic p;
      p = ~(^c);
      if (bad_par) p = ~p;
      send_bit(1'b0);
      for (int i = 0; i < 7; i++) send_bit(c[i]);
      send_bit(p);
      send_bit(bad_stop ? 1'b0 : 1'b1);
      rx = 1'b1;
      if (bad_stop) idle(4);
      model_char(c, bad_par | bad_stop);
      check("pronto_count", pronto_cnt, m_pronto);
      check("erro_count", erro_cnt, m_erro);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_char(7'(s[i]), 1'b0, 1'b0);
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_angulo"}, angulo, m_ang);
      check({tag, "_distancia"}, distancia, m_dist);
   endtask

   initial begin
      logic [6:0] fr[8];
      bit         fault;
      int         pos, kind;

      // reset state
      idle(3);
      check("rst_angulo", angulo, 12'h000);
      check("rst_distancia", distancia, 12'h000);
      check("rst_pronto", pronto, 1'b0);
      check("rst_erro", erro, 1'b0);
      check("rst_db_estado", db_estado, 4'd0);
      check("rst_db_rx_estado", db_rx_estado, 3'd0);
      reset = 1'b1;
      idle(2);

      // first frame after sync
      send_str("#045,123#");
      check_frame("t1");
      check("t1_angulo_const", angulo, 12'h045);
      check("t1_distancia_const", distancia, 12'h123);
      check("t1_no_erro", erro_cnt, 0);

      // back-to-back frames
      send_str("090,007#180,250#");
      check_frame("t2");
      check("t2_angulo_const", angulo, 12'h180);
      check("t2_distancia_const", distancia, 12'h250);
      check("t2_pronto_total", pronto_cnt, 3);

      // parity error drops the frame in progress
      send_char(7'h30, 1'b1, 1'b0);
      send_str("45,123#");
      check_frame("t3a");
      send_str("060,010#");
      check_frame("t3");
      check("t3_angulo_const", angulo, 12'h060);
      check("t3_distancia_const", distancia, 12'h010);

      // format error keeps the last good frame
      send_str("04X,123#");
      check_frame("t4a");
      check("t4_hold_angulo", angulo, 12'h060);
      send_str("321,654#");
      check_frame("t4");

      // short low glitch on idle line
      rx = 1'b0;
      idle(3);
      rx = 1'b1;
      idle(20);
      check("glitch_rx_idle", db_rx_estado, 3'd0);
      check("glitch_erro", erro_cnt, m_erro);
      check("glitch_pronto", pronto_cnt, m_pronto);

      // stop bit of 0 inside a frame
      send_str("5");
      send_char(7'h35, 1'b0, 1'b1);
      send_str("5,555#");
      send_str("246,801#");
      check_frame("t5");

      // randomized frames with occasional injected faults
      for (int f = 0; f < 25; f++) begin
         fault = ($urandom_range(0, 4) == 0);
         pos   = $urandom_range(0, 7);
         kind  = $urandom_range(0, 2);
         for (int i = 0; i < 8; i++) begin
            if (i == 3)      fr[i] = 7'h2C;
            else if (i == 7) fr[i] = 7'h23;
            else             fr[i] = 7'(7'h30 + $urandom_range(0, 9));
         end
         if (fault && kind == 2) fr[pos] = 7'($urandom);
         for (int i = 0; i < 8; i++) begin
            send_char(fr[i], fault && i == pos && kind == 0, fault && i == pos && kind == 1);
            idle($urandom_range(0, 3));
         end
         check_frame("rand");
      end

      // reset in the middle of a character
      send_str("#135,246#");
      check_frame("t6a");
      check("t6_angulo_const", angulo, 12'h135);
      send_str("777,");
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      reset = 1'b0;
      #1;
      check("mid_rst_angulo", angulo, 12'h000);
      check("mid_rst_distancia", distancia, 12'h000);
      check("mid_rst_pronto", pronto, 1'b0);
      check("mid_rst_erro", erro, 1'b0);
      check("mid_rst_db_estado", db_estado, 4'd0);
      check("mid_rst_db_rx_estado", db_rx_estado, 3'd0);
      model_reset();
      rx = 1'b1;
      idle(3);
      reset = 1'b1;
      idle(2);
      send_str("#001,999#");
      check_frame("t6");
      check("t6_angulo_const", angulo, 12'h001);
      check("t6_distancia_const", distancia, 12'h999);

      check("pronto_and_erro_overlap", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
